// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone UART receive path.
// Contents: FSM state codes, parity mode constants, status bit offsets in the read word.
package wb_uart_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_START  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
    localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;
    localparam logic [STATE_W-1:0] ST_BREAK  = 3'd5;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    // Status bit positions above the character in the read word
    localparam int unsigned PARITY_ERR_OFS = 0;
    localparam int unsigned FRAME_ERR_OFS  = 1;
    localparam int unsigned OVERRUN_OFS    = 2;
    localparam int unsigned VALID_OFS      = 3;

endpackage

// File: rtl/wb_uart_rx_fifo_if.sv
// Wishbone read-only data port bundle for the UART receiver.
// Signals: wb_stb_i (read strobe), wb_ack_o (one-cycle ack), wb_dat_o (status + character).
// Modports: slave (peripheral side), master (bus side).
interface wb_uart_rx_fifo_if #(
    parameter int unsigned DW = 12
);
    logic          wb_stb_i;
    logic          wb_ack_o;
    logic [DW-1:0] wb_dat_o;

    modport slave  (input  wb_stb_i, output wb_ack_o, output wb_dat_o);
    modport master (output wb_stb_i, input  wb_ack_o, input  wb_dat_o);
endinterface

// File: rtl/wb_fifo_sync.sv
// Generic synchronous FIFO; a push while full is accepted only if a pop frees a slot the same cycle.
// Ports: clk, rst (async, active-high), push, pop, wdata, rdata_c (head), full_c, empty_c.
module wb_fifo_sync #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full_c,
    output logic             empty_c
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty_c = (count == '0);
    assign full_c  = (count == (AW+1)'(DEPTH));
    assign rdata_c = mem[rd_ptr];
    assign do_pop  = pop && !empty_c;
    assign do_push = push && (!full_c || do_pop);

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wb_uart_rx_fifo.sv
// Parametrised UART receiver with receive FIFO, Wishbone read port and level interrupt.
// Ports: wb_clk_i, wb_rst_i (async, active-high), wb (slave modport: stb/ack/dat),
//        int_uart_rx (FIFO non-empty), uart_rx (async serial line, idle high).
// Optional: UART_RX_MAJORITY_EN enables 2-of-3 majority sampling around each bit centre.
module wb_uart_rx_fifo
    import wb_uart_pkg::*;
#(
    parameter int unsigned TICKS_PER_BAUD = 8,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned PARITY         = 0,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_uart_rx_fifo_if.slave      wb,
    output logic                  int_uart_rx,
    input  logic                  uart_rx
);
    localparam int unsigned CW = $clog2(TICKS_PER_BAUD);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam int unsigned EW = DATA_BITS + 2;
    localparam int unsigned DW = DATA_BITS + 4;
    localparam logic [CW-1:0] BAUD_LAST = CW'(TICKS_PER_BAUD - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] SAMPLE_PT = CW'(TICKS_PER_BAUD/2 + 1);
`else
    localparam logic [CW-1:0] SAMPLE_PT = CW'(TICKS_PER_BAUD/2);
`endif

    logic                 rx_meta, rx_s, rx_bit;
    logic [STATE_W-1:0]   state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 push, sample, wrap;
    logic [EW-1:0]        head;
    logic                 full, empty, rd_req, pop, ovr_q;
    logic                 ack_q;
    logic [DW-1:0]        dat_q;

    // Two-flop synchroniser, preset to the idle level
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Capture the two samples preceding the decision tick; the third is live rx_s
    logic [1:0] vote_q;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            vote_q <= 2'b11;
        end else begin
            if (cnt_q == CW'(TICKS_PER_BAUD/2 - 1)) vote_q[0] <= rx_s;
            if (cnt_q == CW'(TICKS_PER_BAUD/2))     vote_q[1] <= rx_s;
        end
    end
    assign rx_bit = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
    assign rx_bit = rx_s;
`endif

    // Receiver state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
        end
    end

    // Next-state and push decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        push    = 1'b0;
        sample  = (cnt_q == SAMPLE_PT);
        wrap    = (cnt_q == BAUD_LAST);
        if (state_q != ST_IDLE && state_q != ST_BREAK)
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = CW'(1);   // detection cycle already elapsed
                    perr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (sample && rx_bit) begin
                    state_d = ST_IDLE;
                end else if (wrap) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (sample) shift_d = {rx_bit, shift_q[DATA_BITS-1:1]};
                if (wrap) begin
                    if (idx_q == BW'(DATA_BITS - 1))
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    else
                        idx_d = idx_q + BW'(1);
                end
            end
            ST_PARITY: begin
                if (sample) perr_d = ((^shift_q) ^ rx_bit) != (PARITY == PARITY_ODD);
                if (wrap)   state_d = ST_STOP;
            end
            ST_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed
                if (sample) begin
                    push    = 1'b1;
                    state_d = rx_bit ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_req = wb.wb_stb_i && !ack_q;
    assign pop    = rd_req && !empty;

    wb_fifo_sync #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .push    (push),
        .pop     (pop),
        .wdata   ({!rx_bit, perr_q, shift_q}),
        .rdata_c (head),
        .full_c  (full),
        .empty_c (empty)
    );

    // Bus response, sticky overrun (set beats clear) and interrupt
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            ovr_q       <= 1'b0;
            int_uart_rx <= 1'b0;
        end else begin
            ack_q <= rd_req;
            if (rd_req) dat_q <= {!empty, ovr_q, empty ? {EW{1'b0}} : head};
            if (push && full && !pop) ovr_q <= 1'b1;
            else if (rd_req)          ovr_q <= 1'b0;
            int_uart_rx <= !empty;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;

endmodule
